// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store initiator with req/ack handshake, pipeline stall and ack timeout
module mem_access_ctrl #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic [15:0] ex_Address,
    input  logic [15:0] ex_WriteData,
    output logic        stall,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic [15:0] Address,
    output logic [15:0] WriteData,
    output logic        memWrite,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] ReadData
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        accept, legal, timed_out, is_rd;
    logic [7:0]  tcnt;
    logic        mem_req_nx, mem_write_nx, resp_valid_nx, resp_err_nx;
    logic [15:0] resp_data_nx;

    assign accept    = (state == IDLE) && ex_valid && (ex_memRead || ex_memWrite);
    assign legal     = !(ex_memRead && ex_memWrite) && ({1'b0, ex_Address} < DEPTH_W);
    assign timed_out = (state == ACCESS) && !mem_ack && (tcnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = legal ? ACCESS : RESP;
            ACCESS:  if (mem_ack || timed_out) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; stall itself is the only combinational output.
    always_comb begin
        stall         = accept || (state == ACCESS);
        mem_req_nx    = 1'b0;
        mem_write_nx  = 1'b0;
        resp_valid_nx = (state_nx == RESP);
        resp_err_nx   = 1'b0;
        resp_data_nx  = 16'h0000;
        case (state)
            IDLE: begin
                mem_req_nx   = accept && legal;
                mem_write_nx = accept && legal && ex_memWrite;
                resp_err_nx  = accept && !legal;
            end
            ACCESS: begin
                mem_req_nx   = !(mem_ack || timed_out);
                mem_write_nx = memWrite && !(mem_ack || timed_out);
                resp_err_nx  = timed_out;
                if (mem_ack && is_rd) resp_data_nx = ReadData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req    <= 1'b0;
            memWrite   <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 16'h0000;
            Address    <= 16'h0000;
            WriteData  <= 16'h0000;
            is_rd      <= 1'b0;
            tcnt       <= 8'd0;
        end else begin
            mem_req    <= mem_req_nx;
            memWrite   <= mem_write_nx;
            resp_valid <= resp_valid_nx;
            resp_err   <= resp_err_nx;
            resp_data  <= resp_data_nx;
            if (accept && legal) begin
                Address   <= ex_Address;
                WriteData <= ex_WriteData;
                is_rd     <= ex_memRead;
            end
            if (state == ACCESS && !mem_ack) tcnt <= tcnt + 8'd1;
            else                             tcnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid, ex_memRead, ex_memWrite;
    logic [15:0] ex_Address, ex_WriteData;
    logic        stall, resp_valid, resp_err, memWrite, mem_req, mem_ack;
    logic [15:0] resp_data, Address, WriteData, ReadData;

    mem_access_ctrl #(.DEPTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_Address(ex_Address), .ex_WriteData(ex_WriteData),
        .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .Address(Address), .WriteData(WriteData), .memWrite(memWrite), .mem_req(mem_req),
        .mem_ack(mem_ack), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [16:0] sb[$];

    // Memory model: ack after ack_delay cycles of mem_req, or always high when ack_delay is 0.
    logic [15:0] mem[16];
    int ack_delay = 0;
    int wait_cnt = 0;
    int req_cyc = 0;
    int wr_cyc = 0;
    assign mem_ack  = (ack_delay == 0) ? 1'b1 : (mem_req && (wait_cnt >= ack_delay));
    assign ReadData = mem[Address[3:0]];

    always @(posedge clk) begin
        if (mem_req) wait_cnt <= wait_cnt + 1;
        else         wait_cnt <= 0;
        if (mem_req && memWrite && mem_ack) mem[Address[3:0]] <= WriteData;
        if (mem_req)  req_cyc <= req_cyc + 1;
        if (memWrite) wr_cyc  <= wr_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst && resp_valid) begin
            chk("resp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_err", resp_err, e[16]);
                chk("resp_data", resp_data, e[15:0]);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        ex_valid = 1'b1; ex_memRead = rd; ex_memWrite = wr; ex_Address = a; ex_WriteData = d;
        #1 chk("stall_accept", stall, 1);
        @(negedge clk);
        ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
        ex_Address = 16'hffff; ex_WriteData = 16'h0000;
    endtask

    // Waits from the first ACCESS cycle for resp_valid; n = ACCESS cycles, ack_n = cycle of mem_ack.
    task automatic wait_resp(input int max, input logic [15:0] exp_addr, output int n, output int ack_n);
        int bad = 0;
        n = 0; ack_n = -1;
        while (!resp_valid && n < max) begin
            if (Address !== exp_addr || stall !== 1'b1 || mem_req !== 1'b1) bad++;
            if (mem_ack && ack_n < 0) ack_n = n;
            @(negedge clk);
            n++;
        end
        chk("resp_within_bound", 32'(resp_valid), 1);
        chk("access_hold_stable", bad, 0);
        chk("stall_low_on_resp", stall, 0);
    endtask

    initial begin
        int n, ack_n;
        for (int i = 0; i < 16; i++) mem[i] = {4{4'(i)}};
        mem[0] = 16'haaaa;
        ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_Address = 0; ex_WriteData = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_memWrite", memWrite, 0);
        chk("rst_outputs", {Address, WriteData}, 0);
        chk("rst_resp_data", resp_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // ex_valid with no op is not accepted
        ex_valid = 1'b1;
        #1 chk("no_op_no_stall", stall, 0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("no_op_no_req", mem_req, 0);

        // 1: zero-wait load
        req_cyc = 0;
        sb.push_back({1'b0, 16'h3333});
        issue(1, 0, 16'd3, 16'h0);
        chk("t1_req", mem_req, 1);
        chk("t1_addr", Address, 16'd3);
        chk("t1_stall", stall, 1);
        chk("t1_no_early_resp", resp_valid, 0);
        @(negedge clk);
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_stall_low", stall, 0);
        chk("t1_req_dropped", mem_req, 0);
        @(negedge clk);
        chk("t1_resp_one_cycle", resp_valid, 0);
        chk("t1_req_cycles", req_cyc, 1);

        // 2: store then load
        wr_cyc = 0;
        sb.push_back({1'b0, 16'h0000});
        issue(0, 1, 16'd5, 16'hBEEF);
        chk("t2_memWrite", memWrite, 1);
        chk("t2_wdata", WriteData, 16'hBEEF);
        @(negedge clk);
        chk("t2_store_resp", resp_valid, 1);
        @(negedge clk);
        chk("t2_wr_cycles", wr_cyc, 1);
        sb.push_back({1'b0, 16'hBEEF});
        issue(1, 0, 16'd5, 16'h0);
        @(negedge clk);
        chk("t2_load_resp", resp_valid, 1);
        @(negedge clk);

        // 3: slow memory; ex_* wiggles during stall must be ignored
        ack_delay = 4; req_cyc = 0; wr_cyc = 0;
        sb.push_back({1'b0, 16'h9999});
        issue(1, 0, 16'd9, 16'h0);
        ex_valid = 1'b1; ex_memWrite = 1'b1; ex_Address = 16'd2; ex_WriteData = 16'hDEAD;
        wait_resp(20, 16'd9, n, ack_n);
        ex_valid = 1'b0; ex_memWrite = 1'b0;
        chk("t3_access_cycles", n, 5);
        chk("t3_resp_after_ack", n - ack_n, 1);
        @(negedge clk);
        chk("t3_req_cycles", req_cyc, 5);
        chk("t3_no_write", wr_cyc, 0);

        // 4: timeout, then a normal request
        ack_delay = 255; req_cyc = 0;
        sb.push_back({1'b1, 16'h0000});
        issue(1, 0, 16'd4, 16'h0);
        wait_resp(40, 16'd4, n, ack_n);
        chk("t4_access_cycles", n, 15);
        chk("t4_req_dropped", mem_req, 0);
        @(negedge clk);
        chk("t4_req_cycles", req_cyc, 15);
        ack_delay = 0;
        sb.push_back({1'b0, 16'h4444});
        issue(1, 0, 16'd4, 16'h0);
        @(negedge clk);
        chk("t4_recover_resp", resp_valid, 1);
        @(negedge clk);

        // 5: rejects (out of range, read+write)
        req_cyc = 0; wr_cyc = 0;
        sb.push_back({1'b1, 16'h0000});
        issue(1, 0, 16'd16, 16'h0);
        chk("t5_range_resp", resp_valid, 1);
        chk("t5_range_req", mem_req, 0);
        @(negedge clk);
        sb.push_back({1'b1, 16'h0000});
        issue(1, 1, 16'd2, 16'h1234);
        chk("t5_rw_resp", resp_valid, 1);
        @(negedge clk);
        chk("t5_no_req", req_cyc, 0);
        chk("t5_no_write", wr_cyc, 0);

        // 6: reset mid-access aborts a store with no response
        ack_delay = 255;
        issue(0, 1, 16'd7, 16'hCAFE);
        chk("t6_memWrite", memWrite, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_memWrite", memWrite, 0);
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_addr", Address, 0);
        chk("t6_rst_wdata", WriteData, 0);
        chk("t6_rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b1; ack_delay = 0;
        @(negedge clk); @(negedge clk);
        chk("t6_store_aborted", mem[7], 16'h7777);
        sb.push_back({1'b0, 16'haaaa});
        issue(1, 0, 16'd0, 16'h0);
        @(negedge clk);
        chk("t6_fresh_resp", resp_valid, 1);
        @(negedge clk); @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
